// File: rtl/vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_sequencer
// Purpose  : Queues drop/change indications from the vending core and drives
//            the product and change dispensers one at a time through
//            four-phase req/ack handshakes, each phase guarded by a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispense_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     drop_in,
    input  logic                     change_in,
    input  logic                     dispense_ack,
    input  logic                     change_ack,
    input  logic                     fault_clr,
    output logic                     dispense_req,
    output logic                     change_req,
    output logic                     vend_done,
    output logic                     busy,
    output logic                     fault,
    output logic [1:0]               fault_code,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISP_REQ = 3'd1,
        S_DISP_REL = 3'd2,
        S_CHG_REQ  = 3'd3,
        S_CHG_REL  = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t          state_q;
    logic [15:0]     timer_q;
    logic            flag_q;
    logic            disp_req_q;
    logic            chg_req_q;
    logic            done_q;
    logic [1:0]      code_q;

    logic            flags_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            overflow_q;

    logic            push_w;
    logic            pop_w;
    logic            full_w;
    logic            accept_w;
    logic            tmo_w;

    // A full queue still takes a push when the FSM pops in the same cycle.
    assign push_w   = drop_in | change_in;
    assign pop_w    = (state_q == S_IDLE) && (count_q != '0);
    assign full_w   = (count_q == FULL_CNT);
    assign accept_w = push_w && (!full_w || pop_w);
    assign tmo_w    = (timer_q == TMO_LAST);

    // Queue payload storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (accept_w) begin
            flags_q[wr_ptr_q] <= change_in;
        end
    end

    // Queue pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({accept_w, pop_w})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_w && full_w && !pop_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Handshake sequencer with per-state watchdog; outputs set on transitions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            flag_q     <= 1'b0;
            disp_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            done_q     <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop_w) begin
                        flag_q     <= flags_q[rd_ptr_q];
                        state_q    <= S_DISP_REQ;
                        disp_req_q <= 1'b1;
                        timer_q    <= '0;
                    end
                end
                S_DISP_REQ: begin
                    if (dispense_ack) begin
                        state_q    <= S_DISP_REL;
                        disp_req_q <= 1'b0;
                        timer_q    <= '0;
                    end else if (tmo_w) begin
                        state_q    <= S_FAULT;
                        disp_req_q <= 1'b0;
                        code_q     <= 2'b01;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DISP_REL: begin
                    if (!dispense_ack) begin
                        timer_q <= '0;
                        if (flag_q) begin
                            state_q   <= S_CHG_REQ;
                            chg_req_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end else if (tmo_w) begin
                        state_q <= S_FAULT;
                        code_q  <= 2'b01;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_CHG_REQ: begin
                    if (change_ack) begin
                        state_q   <= S_CHG_REL;
                        chg_req_q <= 1'b0;
                        timer_q   <= '0;
                    end else if (tmo_w) begin
                        state_q   <= S_FAULT;
                        chg_req_q <= 1'b0;
                        code_q    <= 2'b10;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_CHG_REL: begin
                    if (!change_ack) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        timer_q <= '0;
                    end else if (tmo_w) begin
                        state_q <= S_FAULT;
                        code_q  <= 2'b10;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_FAULT: begin
                    // Faulted entry is dropped; leave only once mechanisms are released.
                    if (fault_clr && !dispense_ack && !change_ack) begin
                        state_q <= S_IDLE;
                        code_q  <= 2'b00;
                        timer_q <= '0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    disp_req_q <= 1'b0;
                    chg_req_q  <= 1'b0;
                    timer_q    <= '0;
                end
            endcase
        end
    end

    assign dispense_req = disp_req_q;
    assign change_req   = chg_req_q;
    assign vend_done    = done_q;
    assign busy         = (state_q != S_IDLE);
    assign fault        = (state_q == S_FAULT);
    assign fault_code   = code_q;
    assign pending      = count_q;
    assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: doc/vend_dispense_sequencer.md
# vend_dispense_sequencer

Sequences the physical dispense hardware behind the vending FSM core. Captures the core's one-cycle drop/change indications into a small pending queue, then drives the product dispenser and the change dispenser one at a time through four-phase req/ack handshakes. Each handshake phase has a watchdog timeout. A stuck mechanism raises a fault and halts dispensing without losing later purchases.

## Interface
- DEPTH, 4: pending-vend queue depth; power of 2, ≥2.
- TIMEOUT, 1000: max cycles allowed in any handshake state; range 2..65535.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- drop_in  input  1  one-cycle pulse from the vending core; product purchased.
- change_in  input  1  one-cycle pulse from the vending core; change owed (treated as drop + change).
- dispense_ack  input  1  product dispenser acknowledge.
- change_ack  input  1  change dispenser acknowledge.
- fault_clr  input  1  operator fault clear.
- dispense_req  output  1  product dispenser request (registered).
- change_req  output  1  change dispenser request (registered).
- vend_done  output  1  one-cycle pulse when a queued vend fully completes.
- busy  output  1  FSM not in IDLE.
- fault  output  1  FSM in FAULT.
- fault_code  output  2  01 = dispense timeout, 10 = change timeout; 00 otherwise.
- pending  output  $clog2(DEPTH)+1  queue occupancy.
- overflow  output  1  sticky; set when a push is dropped because the queue is full.

## Operation
- Reset (reset_n=0, async): all outputs 0, queue empty, FSM IDLE, timer 0, overflow cleared.
- Push: cycle with drop_in|change_in=1 writes one entry, flag = change_in.
- Push is dropped and overflow set only if the queue is full and no pop occurs in the same cycle. A simultaneous push and pop on a full queue is accepted.
- Pushes are accepted in every FSM state, including FAULT.
- FSM states: IDLE, DISP_REQ, DISP_REL, CHG_REQ, CHG_REL, FAULT.
- IDLE: if queue is not empty, pop the head entry, latch its flag, go to DISP_REQ.
- DISP_REQ: dispense_req=1. When dispense_ack=1, go to DISP_REL.
- DISP_REL: dispense_req=0. When dispense_ack=0:
  - flag=1: go to CHG_REQ.
  - flag=0: pulse vend_done and go to IDLE.
- CHG_REQ: change_req=1. When change_ack=1, go to CHG_REL.
- CHG_REL: change_req=0. When change_ack=0, pulse vend_done and go to IDLE.
- Timeout: a 16-bit timer clears on every state entry and increments in the four handshake states.
  - If the timer reaches TIMEOUT-1 without the exit condition, the next state is FAULT.
  - fault_code = 01 when the timeout occurs in a DISP_* state, 10 when it occurs in a CHG_* state.
- FAULT: both reqs 0, fault=1. Exit to IDLE only when fault_clr=1 and dispense_ack=0 and change_ack=0.
  - The faulted entry is discarded with no vend_done.
  - fault_code clears on exit.
- Only one req is ever high. The two reqs are never high in the same cycle.
- Acks arriving in a state that does not expect them are ignored.

## Timing
- Entry pushed at edge N is visible in pending after edge N.
- If the FSM is IDLE, the pop occurs at edge N+1 and dispense_req=1 after edge N+1. Product latency is 2 cycles from drop_in.
- dispense_req falls one cycle after dispense_ack is sampled high. The next state advances one cycle after ack is sampled low.
- Minimum vend with acks returned combinationally next cycle:
  - drop only: 4 cycles IDLE→IDLE.
  - drop+change: 6 cycles.
- vend_done asserts for exactly the cycle following the final ack-low sample.
- Back-to-back queued vends: IDLE is occupied for 1 cycle between vends.
- Timeout fires after exactly TIMEOUT cycles spent in a single handshake state.
- reset_n deassertion is synchronous to clk at the consumer. Reset mid-handshake drops reqs immediately (async) and empties the queue.

## Test plan
- Single drop: drop_in pulse; dispenser acks after 3 cycles and releases 2 cycles later → dispense_req high 2 cycles after drop_in, one vend_done, change_req never high, pending returns to 0.
- Drop + change: drop_in=change_in=1 pulse; both mechanisms ack → dispense handshake completes before change_req rises, one vend_done at the end of CHG_REL.
- Queue fill/overflow (DEPTH=4): hold dispense_ack=0 and push 6 vends → pending=4 (one entry in service), overflow=1 and sticky. Release acks → exactly 5 vend_done pulses.
- Dispense timeout (TIMEOUT=8): dispense_ack stuck 0 → FAULT after 8 cycles in DISP_REQ, fault_code=01, reqs 0.
  - fault_clr while dispense_ack=1 → ignored.
  - fault_clr with acks 0 → IDLE, the next queued vend is served.
- Change timeout: change_ack held 1 in CHG_REL for TIMEOUT cycles → fault_code=10, no vend_done.
- Async reset mid-CHG_REQ: reset_n low between clock edges → change_req=0 immediately, pending=0, overflow=0. After release, a new drop vends normally.
